// File: rtl/frame_buffer_packer_pkg.sv
// Shared types and helpers for the frame buffer packer: FSM state, plane select,
// and bytes-per-word arithmetic derived from the memory word width.
package fb_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fb_state_t;

    typedef enum logic [1:0] {PLANE_Y, PLANE_U, PLANE_V} fb_plane_t;

    function automatic int fb_bpw(input int mem_width);
        return mem_width / 8;
    endfunction

    function automatic int fb_log2_bpw(input int mem_width);
        return (mem_width / 8 > 1) ? $clog2(mem_width / 8) : 0;
    endfunction

    function automatic int fb_lane_width(input int mem_width);
        return (mem_width / 8 > 1) ? $clog2(mem_width / 8) : 1;
    endfunction

endpackage

// File: rtl/frame_buffer_packer_if.sv
// Byte-stream input and memory write port of the frame buffer packer.
// The packer connects to the slave modport; the source/memory side uses master.
interface frame_buffer_packer_if #(
    parameter int MEM_WIDTH  = 64,
    parameter int ADDR_WIDTH = 24
);
    logic                    pix_valid;
    logic [7:0]              pix_data;
    logic                    pix_ready;
    logic                    mem_wr_en;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [MEM_WIDTH-1:0]    mem_data;
    logic [MEM_WIDTH/8-1:0]  mem_be;
    logic                    mem_ready;

    modport master (
        output pix_valid, pix_data, mem_ready,
        input  pix_ready, mem_wr_en, mem_addr, mem_data, mem_be
    );

    modport slave (
        input  pix_valid, pix_data, mem_ready,
        output pix_ready, mem_wr_en, mem_addr, mem_data, mem_be
    );
endinterface

// File: rtl/frame_buffer_packer_word_packer.sv
// Lane fill buffer plus the single output word register with its valid/ready hold.
// Unwritten lanes of a partial word read as zero with their byte enable low.
module fb_word_packer
    import fb_pkg::*;
#(
    parameter  int MEM_WIDTH  = 64,
    parameter  int ADDR_WIDTH = 24,
    localparam int BPW        = fb_bpw(MEM_WIDTH),
    localparam int LANE_W     = fb_lane_width(MEM_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_byte_we,
    input  logic [7:0]            i_byte,
    input  logic [LANE_W-1:0]     i_lane,
    input  logic                  i_word_end,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_mem_ready,
    output logic                  o_mem_wr_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [MEM_WIDTH-1:0]  o_mem_data,
    output logic [BPW-1:0]        o_mem_be
);

    logic [MEM_WIDTH-1:0]  r_buf_data;
    logic [BPW-1:0]        r_buf_be;
    logic [MEM_WIDTH-1:0]  w_fill_data;
    logic [BPW-1:0]        w_fill_be;

    always_comb begin
        w_fill_data = r_buf_data;
        w_fill_be   = r_buf_be;
        for (int k = 0; k < BPW; k++) begin
            if (i_lane == LANE_W'(k)) begin
                w_fill_data[8*k +: 8] = i_byte;
                w_fill_be[k]          = 1'b1;
            end
        end
    end

    // The completing byte bypasses the buffer straight into the output register,
    // which the caller only allows when that register is free or draining.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_buf_data  <= '0;
            r_buf_be    <= '0;
            o_mem_wr_en <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_data  <= '0;
            o_mem_be    <= '0;
        end else if (i_byte_we && i_word_end) begin
            r_buf_data  <= '0;
            r_buf_be    <= '0;
            o_mem_wr_en <= 1'b1;
            o_mem_addr  <= i_addr;
            o_mem_data  <= w_fill_data;
            o_mem_be    <= w_fill_be;
        end else begin
            if (i_byte_we) begin
                r_buf_data <= w_fill_data;
                r_buf_be   <= w_fill_be;
            end
            if (i_mem_ready) begin
                o_mem_wr_en <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/frame_buffer_packer.sv
// Packs a planar YUV 4:2:0 byte stream into strided memory words.
// Define FB_CHROMA_PLANES_EN to process U and V; otherwise the frame is luma-only.
module frame_buffer_packer
    import fb_pkg::*;
#(
    parameter int MEM_WIDTH  = 64,
    parameter int ADDR_WIDTH = 24,
    parameter int DIM_WIDTH  = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_setup_frame,
    input  logic [DIM_WIDTH-1:0] i_stride,
    input  logic [DIM_WIDTH-1:0] i_width,
    input  logic [DIM_WIDTH-1:0] i_height,
    output logic                 o_busy,
    output logic                 o_frame_done,
    frame_buffer_packer_if.slave bus
);

    localparam int BPW    = fb_bpw(MEM_WIDTH);
    localparam int LBPW   = fb_log2_bpw(MEM_WIDTH);
    localparam int LANE_W = fb_lane_width(MEM_WIDTH);
    localparam int BAW    = ADDR_WIDTH + LBPW;

    fb_state_t             r_state;
    fb_state_t             w_next_state;
    logic [DIM_WIDTH-1:0]  r_stride;
    logic [DIM_WIDTH-1:0]  r_width;
    logic [DIM_WIDTH-1:0]  r_height;
    logic [DIM_WIDTH-1:0]  r_row;
    logic [DIM_WIDTH-1:0]  r_col;
    logic [DIM_WIDTH-1:0]  r_word_off;
    logic [LANE_W-1:0]     r_lane;
    logic [BAW-1:0]        r_row_base;
    logic                  r_bytes_done;

    logic [DIM_WIDTH-1:0]  w_plane_w;
    logic [DIM_WIDTH-1:0]  w_plane_h;
    logic [DIM_WIDTH-1:0]  w_plane_s;
    logic                  w_last_plane;
    logic                  w_pix_ready;
    logic                  w_accept;
    logic                  w_stall;
    logic                  w_row_end;
    logic                  w_lane_end;
    logic                  w_word_end;
    logic                  w_plane_end;
    logic [BAW-1:0]        w_byte_addr;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic                  w_mem_wr_en;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [MEM_WIDTH-1:0]  w_mem_data;
    logic [BPW-1:0]        w_mem_be;

`ifdef FB_CHROMA_PLANES_EN
    fb_plane_t r_plane;
    logic      w_chroma_next;

    assign w_chroma_next = ((r_width >> 1) != '0) && ((r_height >> 1) != '0);
    assign w_last_plane  = (r_plane == PLANE_V) || ((r_plane == PLANE_Y) && !w_chroma_next);

    always_comb begin
        w_plane_w = r_width;
        w_plane_h = r_height;
        w_plane_s = r_stride;
        if (r_plane != PLANE_Y) begin
            w_plane_w = r_width >> 1;
            w_plane_h = r_height >> 1;
            w_plane_s = r_stride >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_setup_frame) begin
            r_plane <= PLANE_Y;
        end else if (w_accept && w_plane_end && !w_last_plane) begin
            r_plane <= (r_plane == PLANE_Y) ? PLANE_U : PLANE_V;
        end
    end
`else
    assign w_last_plane = 1'b1;
    assign w_plane_w    = r_width;
    assign w_plane_h    = r_height;
    assign w_plane_s    = r_stride;
`endif

    assign w_stall     = w_mem_wr_en && !bus.mem_ready;
    assign w_pix_ready = (r_state == RUN) && !r_bytes_done && !w_stall;
    assign w_accept    = bus.pix_valid && w_pix_ready;
    assign w_row_end   = (r_col == w_plane_w - DIM_WIDTH'(1));
    assign w_lane_end  = (r_lane == LANE_W'(BPW - 1));
    assign w_word_end  = w_row_end || w_lane_end;
    assign w_plane_end = w_row_end && (r_row == w_plane_h - DIM_WIDTH'(1));
    assign w_byte_addr = r_row_base + BAW'(r_word_off);
    assign w_word_addr = ADDR_WIDTH'(w_byte_addr / BAW'(BPW));

    // Row base keeps advancing across plane boundaries, so after the last Y row it
    // already equals S*H (U base) and after the last U row it equals the V base.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stride     <= '0;
            r_width      <= '0;
            r_height     <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_word_off   <= '0;
            r_lane       <= '0;
            r_row_base   <= '0;
            r_bytes_done <= 1'b0;
        end else if (i_setup_frame) begin
            r_stride     <= i_stride;
            r_width      <= i_width;
            r_height     <= i_height;
            r_row        <= '0;
            r_col        <= '0;
            r_word_off   <= '0;
            r_lane       <= '0;
            r_row_base   <= '0;
            r_bytes_done <= (i_width == '0) || (i_height == '0);
        end else if (w_accept) begin
            if (w_row_end) begin
                r_col      <= '0;
                r_lane     <= '0;
                r_word_off <= '0;
                r_row_base <= r_row_base + BAW'(w_plane_s);
                if (w_plane_end) begin
                    r_row <= '0;
                    if (w_last_plane) begin
                        r_bytes_done <= 1'b1;
                    end
                end else begin
                    r_row <= r_row + DIM_WIDTH'(1);
                end
            end else begin
                r_col <= r_col + DIM_WIDTH'(1);
                if (w_lane_end) begin
                    r_lane     <= '0;
                    r_word_off <= r_word_off + DIM_WIDTH'(BPW);
                end else begin
                    r_lane <= r_lane + LANE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The frame ends once every byte is in and the last word has left the output register.
    always_comb begin
        w_next_state = r_state;
        o_busy       = 1'b0;
        o_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_setup_frame) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                o_busy = 1'b1;
                if (i_setup_frame) begin
                    w_next_state = RUN;
                end else if (r_bytes_done && !w_stall) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                o_frame_done = 1'b1;
                w_next_state = i_setup_frame ? RUN : IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    fb_word_packer #(
        .MEM_WIDTH  (MEM_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_word_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (i_setup_frame),
        .i_byte_we   (w_accept),
        .i_byte      (bus.pix_data),
        .i_lane      (r_lane),
        .i_word_end  (w_word_end),
        .i_addr      (w_word_addr),
        .i_mem_ready (bus.mem_ready),
        .o_mem_wr_en (w_mem_wr_en),
        .o_mem_addr  (w_mem_addr),
        .o_mem_data  (w_mem_data),
        .o_mem_be    (w_mem_be)
    );

    assign bus.pix_ready = w_pix_ready;
    assign bus.mem_wr_en = w_mem_wr_en;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_data  = w_mem_data;
    assign bus.mem_be    = w_mem_be;

endmodule

// File: tb/tb_frame_buffer_packer.sv
// Self-checking bench for frame_buffer_packer: geometry table, randomized frames
// against an address-arithmetic reference model, and hand-written corner sequences.
module tb_frame_buffer_packer;

    localparam int MW    = 64;
    localparam int AW    = 24;
    localparam int DW    = 12;
    localparam int BPW   = MW / 8;
    localparam int LIMIT = 4000;
    localparam int NEVER = 100000;

`ifdef FB_CHROMA_PLANES_EN
    localparam bit CHROMA = 1'b1;
`else
    localparam bit CHROMA = 1'b0;
`endif

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          setup  = 1'b0;
    logic [DW-1:0] stride = '0;
    logic [DW-1:0] width  = '0;
    logic [DW-1:0] height = '0;
    logic          busy;
    logic          frameDone;

    frame_buffer_packer_if #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW)) bus();

    frame_buffer_packer #(
        .MEM_WIDTH  (MW),
        .ADDR_WIDTH (AW),
        .DIM_WIDTH  (DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_setup_frame (setup),
        .i_stride      (stride),
        .i_width       (width),
        .i_height      (height),
        .o_busy        (busy),
        .o_frame_done  (frameDone),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]  addr;
        logic [MW-1:0]  data;
        logic [BPW-1:0] be;
    } wr_t;

    typedef struct {
        int s;
        int w;
        int h;
        int validPct;
        int readyPct;
        int expLuma;
        int expChroma;
    } vec_t;

    wr_t        got[$];
    wr_t        expWr[$];
    logic [7:0] stream[$];
    vec_t       vecs[6];
    int         checks      = 0;
    int         failures    = 0;
    int         doneCount   = 0;
    int         stallErrors = 0;
    wr_t        held;
    bit         heldValid   = 1'b0;

    // Write-port monitor: logs accepted words, frame_done pulses and stall behaviour.
    always @(negedge clk) begin
        if (bus.mem_wr_en && bus.mem_ready) begin
            got.push_back('{bus.mem_addr, bus.mem_data, bus.mem_be});
        end
        if (frameDone) doneCount++;
        if (heldValid && bus.mem_wr_en &&
            (held.addr !== bus.mem_addr || held.data !== bus.mem_data || held.be !== bus.mem_be))
            stallErrors++;
        if (bus.mem_wr_en && !bus.mem_ready && bus.pix_ready) stallErrors++;
        heldValid = bus.mem_wr_en && !bus.mem_ready;
        held      = '{bus.mem_addr, bus.mem_data, bus.mem_be};
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int totalBytes(input int w, input int h);
        int t = w * h;
        if (CHROMA) t += 2 * (w / 2) * (h / 2);
        return t;
    endfunction

    function automatic void fillStream(input int n, input bit randomData);
        stream.delete();
        for (int i = 0; i < n; i++) stream.push_back(randomData ? 8'($urandom) : 8'(i));
    endfunction

    // Reference: every byte lands at base + row*stride + col; words group bytes of one row.
    function automatic void buildExpected(input int s, input int w, input int h);
        int  pw[3];
        int  ph[3];
        int  ps[3];
        int  base[3];
        int  nPlanes;
        int  idx = 0;
        int  byteAddr;
        int  lane;
        wr_t cur;
        bit  curValid = 1'b0;
        expWr.delete();
        pw   = '{w, w / 2, w / 2};
        ph   = '{h, h / 2, h / 2};
        ps   = '{s, s / 2, s / 2};
        base = '{0, s * h, s * h + (s / 2) * (h / 2)};
        nPlanes = CHROMA ? 3 : 1;
        if (w == 0 || h == 0) nPlanes = 0;
        for (int p = 0; p < nPlanes; p++) begin
            for (int r = 0; r < ph[p]; r++) begin
                for (int c = 0; c < pw[p]; c++) begin
                    byteAddr = base[p] + r * ps[p] + c;
                    lane     = byteAddr % BPW;
                    if (c == 0 || lane == 0) begin
                        if (curValid) expWr.push_back(cur);
                        cur.addr = AW'(byteAddr / BPW);
                        cur.data = '0;
                        cur.be   = '0;
                        curValid = 1'b1;
                    end
                    cur.data[8*lane +: 8] = stream[idx];
                    cur.be[lane]          = 1'b1;
                    idx++;
                end
            end
        end
        if (curValid) expWr.push_back(cur);
    endfunction

    function automatic int countMismatch();
        int m = 0;
        int n = (got.size() > expWr.size()) ? got.size() : expWr.size();
        for (int i = 0; i < n; i++) begin
            if (i >= got.size() || i >= expWr.size()) m++;
            else if (got[i].addr !== expWr[i].addr || got[i].data !== expWr[i].data ||
                     got[i].be !== expWr[i].be) m++;
        end
        return m;
    endfunction

    function automatic wr_t getWr(input int i);
        wr_t z;
        z = '{'0, '0, '0};
        if (i < got.size()) return got[i];
        return z;
    endfunction

    task automatic startFrame(input int s, input int w, input int h);
        @(posedge clk); #1;
        setup         = 1'b1;
        stride        = DW'(s);
        width         = DW'(w);
        height        = DW'(h);
        bus.pix_valid = 1'b0;
        @(posedge clk); #1;
        setup = 1'b0;
    endtask

    task automatic applyStimulus(input int validPct, input int readyPct, input int stallAt, output bit timedOut);
        int idx = 0;
        int cyc = 0;
        bit fin = 1'b0;
        bit acc;
        while (!fin && cyc < LIMIT) begin
            bus.pix_valid = (idx < stream.size()) && ($urandom_range(99) < validPct);
            bus.pix_data  = (idx < stream.size()) ? stream[idx] : 8'h00;
            bus.mem_ready = (cyc >= stallAt && cyc < stallAt + 5) ? 1'b0 : ($urandom_range(99) < readyPct);
            @(negedge clk);
            acc = bus.pix_valid && bus.pix_ready;
            fin = frameDone;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        bus.pix_valid = 1'b0;
        bus.mem_ready = 1'b1;
        timedOut = !fin;
    endtask

    task automatic runFrame(input string name, input int s, input int w, input int h, input int validPct,
                            input int readyPct, input int stallAt, input bit randomData, input int expCount);
        bit to;
        fillStream(totalBytes(w, h), randomData);
        buildExpected(s, w, h);
        got.delete();
        doneCount = 0;
        startFrame(s, w, h);
        applyStimulus(validPct, readyPct, stallAt, to);
        repeat (2) @(posedge clk);
        #1;
        checkOutput({name, " timeout"}, 128'(to), 128'(0));
        checkOutput({name, " write count"}, 128'(got.size()), 128'((expCount < 0) ? expWr.size() : expCount));
        checkOutput({name, " content"}, 128'(countMismatch()), 128'(0));
        checkOutput({name, " frame_done pulses"}, 128'(doneCount), 128'(1));
    endtask

    initial begin
        bit to;
        int pixReadySeen;
        int s;
        int w;
        int h;

        vecs[0] = '{16, 16, 2, 100, 100,  4,  6};
        vecs[1] = '{16, 12, 1, 100, 100,  2,  2};
        vecs[2] = '{32, 20, 4,  70,  60, 12, 20};
        vecs[3] = '{16,  1, 3,  80,  80,  3,  3};
        vecs[4] = '{16,  5, 1, 100,  50,  1,  1};
        vecs[5] = '{64, 40, 6,  60,  70, 30, 48};

        bus.pix_valid = 1'b0;
        bus.pix_data  = 8'h00;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset outputs",
                    {busy, frameDone, bus.mem_wr_en, bus.mem_addr, bus.mem_data, bus.mem_be, bus.pix_ready}, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            runFrame($sformatf("vec%0d", i), vecs[i].s, vecs[i].w, vecs[i].h, vecs[i].validPct,
                     vecs[i].readyPct, NEVER, 1'b0, CHROMA ? vecs[i].expChroma : vecs[i].expLuma);
            if (i == 0) begin
                checkOutput("vec0 first addr", 128'(getWr(0).addr), 128'(0));
                checkOutput("vec0 first data", 128'(getWr(0).data), 128'(64'h0706050403020100));
                checkOutput("vec0 last addr", 128'(getWr(got.size() - 1).addr), 128'(CHROMA ? 5 : 3));
            end
            if (i == 1) begin
                checkOutput("vec1 second addr", 128'(getWr(1).addr), 128'(1));
                checkOutput("vec1 second be", 128'(getWr(1).be), 128'(8'h0F));
                checkOutput("vec1 second data", 128'(getWr(1).data), 128'(64'h0000_0000_0B0A_0908));
            end
        end

        stallErrors = 0;
        runFrame("stall", 16, 16, 2, 100, 100, 6, 1'b1, CHROMA ? 6 : 4);
        checkOutput("stall bus hold", 128'(stallErrors), 128'(0));

        for (int n = 0; n < 4; n++) begin
            s = 16 * int'($urandom_range(1, 4));
            w = int'($urandom_range(0, s));
            h = int'($urandom_range(0, 5));
            runFrame($sformatf("rand%0d", n), s, w, h, int'($urandom_range(40, 100)),
                     int'($urandom_range(40, 100)), NEVER, 1'b1, -1);
        end

        // Abort mid-row with a word waiting in the output register.
        doneCount = 0;
        startFrame(16, 16, 2);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = 8'(8'hA0 + i);
            @(posedge clk); #1;
        end
        bus.pix_valid = 1'b0;
        checkOutput("abort word pending", 128'(bus.mem_wr_en), 128'(1));
        fillStream(totalBytes(16, 16), 1'b1);
        buildExpected(16, 16, 2);
        got.delete();
        startFrame(16, 16, 2);
        checkOutput("abort drops word", 128'(bus.mem_wr_en), 128'(0));
        checkOutput("abort busy", 128'(busy), 128'(1));
        applyStimulus(100, 100, NEVER, to);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("abort timeout", 128'(to), 128'(0));
        checkOutput("abort first addr", 128'(getWr(0).addr), 128'(0));
        checkOutput("abort content", 128'(countMismatch()), 128'(0));
        checkOutput("abort frame_done pulses", 128'(doneCount), 128'(1));

        // Reset mid-frame with a pending word, then bytes must be ignored.
        startFrame(16, 16, 2);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = 8'(8'h50 + i);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("midframe reset outputs",
                    {busy, frameDone, bus.mem_wr_en, bus.mem_addr, bus.mem_data, bus.mem_be, bus.pix_ready}, '0);
        got.delete();
        bus.mem_ready = 1'b1;
        pixReadySeen  = 0;
        for (int i = 0; i < 5; i++) begin
            bus.pix_valid = 1'b1;
            @(negedge clk);
            if (bus.pix_ready) pixReadySeen++;
            @(posedge clk); #1;
        end
        bus.pix_valid = 1'b0;
        checkOutput("idle pix_ready", 128'(pixReadySeen), 128'(0));
        checkOutput("idle writes", 128'(got.size()), 128'(0));
        runFrame("post reset", 16, 12, 1, 100, 100, NEVER, 1'b1, 2);

        // Zero-width frame: done two cycles after the setup cycle, no writes.
        got.delete();
        @(posedge clk); #1;
        setup  = 1'b1;
        stride = DW'(16);
        width  = DW'(0);
        height = DW'(4);
        @(posedge clk); #1;
        setup = 1'b0;
        checkOutput("w0 busy", 128'(busy), 128'(1));
        checkOutput("w0 done early", 128'(frameDone), 128'(0));
        @(posedge clk); #1;
        checkOutput("w0 done", 128'(frameDone), 128'(1));
        @(posedge clk); #1;
        checkOutput("w0 done single", {busy, frameDone}, 128'(0));
        checkOutput("w0 writes", 128'(got.size()), 128'(0));

        checkOutput("global bus hold", 128'(stallErrors), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_buffer_packer.md
Name: frame_buffer_packer

Overview:
- Parametrised successor to the frame buffer write path. Accepts a raw 8-bit planar YUV 4:2:0 byte stream (Y, then U, then V) and packs bytes into MEM_WIDTH-bit memory words.
- Generates strided word addresses per plane, with byte enables for partial words at row ends.
- Sits between the byte source (file reader / capture front end) and the frame memory write port. Frame geometry is latched by a one-cycle setup_frame strobe.

Parameters:
- MEM_WIDTH, 64, memory word width in bits; multiple of 8, 8..256; BPW = MEM_WIDTH/8 bytes per word.
- ADDR_WIDTH, 24, memory word address width.
- DIM_WIDTH, 12, width of stride/width/height inputs.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- setup_frame  in  1  one-cycle strobe; latches geometry and starts a frame.
- stride_in  in  DIM_WIDTH  luma line stride in bytes; multiple of 2*BPW.
- width_in  in  DIM_WIDTH  luma width in pixels.
- height_in  in  DIM_WIDTH  luma height in lines.
- pix_valid  in  1  pix_data valid.
- pix_data  in  8  one sample byte.
- pix_ready  out  1  byte accepted when pix_valid && pix_ready.
- mem_wr_en  out  1  write request; held until mem_ready.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_data  out  MEM_WIDTH  packed word; byte k at bits [8k+7:8k] (little-endian).
- mem_be  out  MEM_WIDTH/8  byte enables.
- mem_ready  in  1  memory accepts the word when mem_wr_en && mem_ready.
- busy  out  1  high from setup until frame end.
- frame_done  out  1  one-cycle pulse after the last word of the frame is accepted.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All outputs are 0; state = IDLE.
  - Geometry registers, counters and pack buffer are cleared.
  - Applies from any state and discards any pending word.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on setup_frame.
  - RUN -> DONE when the final word of the last plane is accepted.
  - DONE -> IDLE unconditionally; frame_done = 1 for exactly that cycle.
- Setup:
  - setup_frame in any state latches stride, width and height, resets plane to Y, row/col to 0, clears the pack buffer and enters RUN on the next cycle.
  - busy rises the cycle after setup_frame.
  - setup_frame during RUN aborts the frame: no frame_done, and any pending word is dropped with mem_wr_en deasserted.
- Plane geometry:
  - Y: width W, height H, stride S, base 0.
  - U: W>>1, H>>1, S>>1, base S*H.
  - V: same dimensions as U, base S*H + (S>>1)*(H>>1).
  - Byte addresses are computed in ADDR_WIDTH+log2(BPW) bits; mem_addr = byte address / BPW.
- Packing:
  - Each accepted byte goes into lane (col mod BPW).
  - A word is emitted when its BPW lanes are filled, or at the last column of a row (partial word, mem_be = lanes written).
  - Full words carry mem_be all ones.
  - A row always starts at lane 0 of a fresh word.
- Handshake:
  - One output register. pix_ready = RUN && !(mem_wr_en && !mem_ready).
  - The byte that completes a word may be accepted while the previous word is being accepted (mem_ready=1) in the same cycle, giving one byte per cycle sustained throughput.
  - mem_addr, mem_data and mem_be are stable while mem_wr_en=1 and mem_ready=0.
- Latency: the completing byte is accepted at edge N; mem_wr_en=1 after edge N.
- Boundaries:
  - W=0 or H=0: RUN goes to DONE on the next cycle with no writes.
  - W or H = 1: chroma dimension becomes 0, so that plane is skipped.
  - Bytes presented in IDLE or DONE are not accepted (pix_ready=0).
  - Counter wrap: the row counter resets per plane.

Optional Feature:
- Macro FB_CHROMA_PLANES_EN.
  - Defined: Y, U and V planes are processed as above.
  - Undefined: luma-only; the frame ends after the last Y word, and chroma address logic is not synthesised.

Decomposition:
- Shared package fb_pkg holds:
  - state enum fb_state_t {IDLE, RUN, DONE};
  - plane enum fb_plane_t {PLANE_Y, PLANE_U, PLANE_V};
  - constant function for BPW/log2(BPW).
- One natural sub-module, fb_word_packer: lane fill, mem_be generation and output-register handshake.
- The top level owns geometry, counters, address generation and the FSM.

Test Plan:
- MEM_WIDTH=64, setup S=16, W=16, H=2, bytes 0x00..0x1F then 16 chroma bytes:
  - Y words at addr 0,1,2,3, first word data 0x0706050403020100;
  - U at addr 4, V at addr 5;
  - frame_done pulses once.
- W=12, S=16, H=1, luma-only build:
  - two writes; second at addr 1 with mem_be=0x0F and bytes 0x08..0x0B in the low lanes.
- Hold mem_ready=0 for 5 cycles mid-frame:
  - pix_ready=0 and the write bus stays stable;
  - no bytes are lost; total write count is unchanged.
- setup_frame mid-row:
  - pending word dropped, no frame_done;
  - the new frame's first write is at addr 0.
- rst_n=0 for one cycle mid-frame:
  - all outputs 0 next cycle, IDLE;
  - bytes are ignored until the next setup_frame.
- W=0, H=4 -> zero writes, frame_done two cycles after setup_frame.
